// File: rtl/fp_pkg.sv
// Shared binary32 rounding encodings and constants for the FMUL32 datapath.
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } r_mode_e;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_e;

    // Bit positions inside the 4-bit {NV, OF, UF, NX} flag vector
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  INF_EXP = 8'hFF;
    localparam logic [31:0] MAXFIN  = 32'h7F7F_FFFF;

    // On overflow a mode that rounds away from zero for this sign saturates to inf
    function automatic logic ovf_to_inf(input r_mode_e r_mode, input logic sign);
        return (r_mode == RM_RNE) ||
               ((r_mode == RM_RUP) && !sign) ||
               ((r_mode == RM_RDN) && sign);
    endfunction

endpackage

// File: rtl/fp_round_incr.sv
// Round-increment decision shared by the multiply (and later add) rounding stages.
module fp_round_incr
    import fp_pkg::*;
(
    input  r_mode_e r_mode,
    input  logic    sign,
    input  logic    lsb,
    input  logic    guard,
    input  logic    sticky,
    output logic    inc,
    output logic    nx
);

    assign nx = guard | sticky;

    // Decide whether the kept fraction must be bumped by one ulp
    always_comb begin
        inc = 1'b0;
        unique case (r_mode)
            RM_RNE: inc = guard & (sticky | lsb);
            RM_RTZ: inc = 1'b0;
            RM_RUP: inc = ~sign & (guard | sticky);
            RM_RDN: inc = sign & (guard | sticky);
        endcase
    end

endmodule

// File: rtl/fmul32_round.sv
// Two-stage normalize / round-and-pack pipeline behind the FMUL32 multiplier.
module fmul32_round
    import fp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    localparam int PW    = 2 * (MANT_W + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W+1:0] in_exp,
    input  logic [PW-1:0]           in_mant,
    input  logic [1:0]              in_class,
    input  logic                    in_invalid,
    input  logic [1:0]              in_r_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_result,
    output logic [3:0]              out_flags
);

    localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W+1:0] EXP_OVF  = (EXP_W+2)'((1 << EXP_W) - 1);

    // handshake
    logic s1_valid;
    logic s2_valid;
    logic s2_ready;
    logic s1_advance;
    logic in_fire;

    assign s2_ready   = ~s2_valid | out_ready;
    assign s1_advance = s1_valid & s2_ready;
    assign in_ready   = ~s1_valid | s1_advance;
    assign in_fire    = in_valid & in_ready;
    assign out_valid  = s2_valid;

    // stage 1 normalize
    logic                    n_guard;
    logic                    n_sticky;
    logic [MANT_W-1:0]       n_frac;
    logic signed [EXP_W+1:0] n_exp;

    // A product in [2,4) has its leading one at the top bit; shift it down one place
    always_comb begin
        if (in_mant[PW-1]) begin
            n_frac   = in_mant[PW-2 -: MANT_W];
            n_guard  = in_mant[PW-2-MANT_W];
            n_sticky = |in_mant[PW-3-MANT_W:0];
            n_exp    = in_exp + EXP_ONE;
        end else begin
            n_frac   = in_mant[PW-3 -: MANT_W];
            n_guard  = in_mant[PW-3-MANT_W];
            n_sticky = |in_mant[PW-4-MANT_W:0];
            n_exp    = in_exp;
        end
    end

    logic                    s1_sign;
    logic signed [EXP_W+1:0] s1_exp;
    logic [MANT_W-1:0]       s1_frac;
    logic                    s1_guard;
    logic                    s1_sticky;
    fp_class_e               s1_class;
    logic                    s1_invalid;
    r_mode_e                 s1_r_mode;

    // Stage 1 occupancy: fills on accept, empties when it hands off to stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 payload captured on accept only
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_sign    <= in_sign;
            s1_exp     <= n_exp;
            s1_frac    <= n_frac;
            s1_guard   <= n_guard;
            s1_sticky  <= n_sticky;
            s1_class   <= fp_class_e'(in_class);
            s1_invalid <= in_invalid;
            s1_r_mode  <= r_mode_e'(in_r_mode);
        end
    end

    // stage 2 round and pack
    logic                    rnd_inc;
    logic                    rnd_nx;
    logic [MANT_W:0]         frac_sum;
    logic signed [EXP_W+1:0] exp_r;
    logic [DATA_W-1:0]       res_d;
    logic [3:0]              flags_d;

    fp_round_incr u_round_incr (
        .r_mode (s1_r_mode),
        .sign   (s1_sign),
        .lsb    (s1_frac[0]),
        .guard  (s1_guard),
        .sticky (s1_sticky),
        .inc    (rnd_inc),
        .nx     (rnd_nx)
    );

    // An all-ones fraction plus one carries out: fraction wraps to zero, exponent bumps
    assign frac_sum = {1'b0, s1_frac} + {{MANT_W{1'b0}}, rnd_inc};
    assign exp_r    = s1_exp + (frac_sum[MANT_W] ? EXP_ONE : EXP_ZERO);

    // Special classes bypass rounding; normals flush on underflow or saturate on overflow
    always_comb begin
        res_d            = '0;
        flags_d          = '0;
        flags_d[FLAG_NV] = s1_invalid;
        case (s1_class)
            CLS_ZERO: res_d = {s1_sign, {(DATA_W-1){1'b0}}};
            CLS_INF:  res_d = {s1_sign, INF_EXP, {MANT_W{1'b0}}};
            CLS_NAN:  res_d = QNAN;
            default: begin
                if (s1_exp <= EXP_ZERO) begin
                    res_d            = {s1_sign, {(DATA_W-1){1'b0}}};
                    flags_d[FLAG_UF] = 1'b1;
                    flags_d[FLAG_NX] = 1'b1;
                end else if (exp_r >= EXP_OVF) begin
                    flags_d[FLAG_OF] = 1'b1;
                    flags_d[FLAG_NX] = 1'b1;
                    if (ovf_to_inf(s1_r_mode, s1_sign)) begin
                        res_d = {s1_sign, INF_EXP, {MANT_W{1'b0}}};
                    end else begin
                        res_d = {s1_sign, MAXFIN[DATA_W-2:0]};
                    end
                end else begin
                    res_d            = {s1_sign, exp_r[EXP_W-1:0], frac_sum[MANT_W-1:0]};
                    flags_d[FLAG_NX] = rnd_nx;
                end
            end
        endcase
    end

    // Output register: loads on hand-off, holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s1_advance) begin
            s2_valid   <= 1'b1;
            out_result <= res_d;
            out_flags  <= flags_d;
        end else if (out_ready) begin
            s2_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fmul32_round.sv
// Self-checking bench for fmul32_round: directed cases plus randomized traffic vs an arithmetic model.
module tb_fmul32_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic [1:0]  in_class;
    logic        in_invalid;
    logic [1:0]  in_r_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int n_checks = 0;
    int n_errors = 0;

    logic [35:0] sb[$];

    fmul32_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_class   (in_class),
        .in_invalid (in_invalid),
        .in_r_mode  (in_r_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: value-level rounding of the integer significand, returns {flags, result}
    function automatic logic [35:0] model(input bit s, input int e_in, input longint unsigned m,
                                          input int c, input bit inv, input int rm);
        longint unsigned q, rem, half;
        int e, sh;
        bit nx, up, away;
        if (c == 1) return {inv, 3'b000, s, 31'd0};
        if (c == 2) return {inv, 3'b000, s, 31'h7F80_0000};
        if (c == 3) return {inv, 3'b000, 32'h7FC0_0000};
        if (m >= 64'h8000_0000_0000) begin
            sh = 24;
            e  = e_in + 1;
        end else begin
            sh = 23;
            e  = e_in;
        end
        q    = m >> sh;
        rem  = m - (q << sh);
        half = 64'd1 << (sh - 1);
        nx   = (rem != 0);
        case (rm)
            0:       up = (rem > half) || ((rem == half) && (q % 2 == 1));
            1:       up = 1'b0;
            2:       up = !s && nx;
            default: up = s && nx;
        endcase
        if (e <= 0) return {inv, 3'b011, s, 31'd0};
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            away = (rm == 0) || (rm == 2 && !s) || (rm == 3 && s);
            return away ? {inv, 3'b101, s, 31'h7F80_0000} : {inv, 3'b101, s, 31'h7F7F_FFFF};
        end
        return {inv, 2'b00, nx, s, 8'(e), 23'(q)};
    endfunction

    function automatic logic [35:0] model_now();
        return model(in_sign, int'($signed(in_exp)), in_mant, int'(in_class), in_invalid, int'(in_r_mode));
    endfunction

    task automatic apply(input bit s, input int e, input logic [47:0] m, input logic [1:0] c,
                         input bit inv, input logic [1:0] rm);
        in_sign    = s;
        in_exp     = 10'(e);
        in_mant    = m;
        in_class   = c;
        in_invalid = inv;
        in_r_mode  = rm;
    endtask

    // One isolated transaction: checks acceptance, 2-edge latency, value and drain
    task automatic run_one(input string tag, input bit s, input int e, input logic [47:0] m,
                           input logic [1:0] c, input bit inv, input logic [1:0] rm,
                           input logic [35:0] want);
        logic [35:0] mdl;
        apply(s, e, m, c, inv, rm);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        mdl = model_now();
        chk({tag, "_rdy"}, 40'(in_ready), 40'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_lat1"}, 40'(out_valid), 40'd0);
        @(negedge clk);
        #1;
        chk({tag, "_lat2"}, 40'(out_valid), 40'd1);
        chk(tag, 40'({out_flags, out_result}), 40'(want));
        chk({tag, "_mdl"}, 40'({out_flags, out_result}), 40'(mdl));
        @(negedge clk);
        #1;
        chk({tag, "_drain"}, 40'(out_valid), 40'd0);
    endtask

    task automatic rand_inputs();
        logic [47:0] m;
        int k;
        int r;
        in_sign   = 1'($urandom % 2);
        in_exp    = 10'(int'($urandom_range(280, 0)) - 10);
        in_r_mode = 2'($urandom % 4);
        m = {16'($urandom), 32'($urandom)};
        if ($urandom % 2 == 1) begin
            m[47] = 1'b1;
        end else begin
            m[47] = 1'b0;
            m[46] = 1'b1;
        end
        k = int'($urandom % 4);
        if (k == 1) m[23:0] = '0;
        if (k == 2) m[23:0] = ($urandom % 2 == 1) ? 24'h80_0000 : 24'h40_0000;
        if (k == 3) m[46:23] = '1;
        in_mant    = m;
        r          = int'($urandom % 16);
        in_class   = (r < 3) ? 2'(r + 1) : 2'd0;
        in_invalid = ($urandom % 8 == 0);
    endtask

    logic [35:0] exp_a, exp_b, exp_c;
    logic        hold;
    logic [35:0] held;
    logic        fire_in, fire_out;
    int          guard_cnt;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        apply(0, 127, 48'h4000_0000_0000, 2'd0, 0, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 40'(out_valid), 40'd0);
        chk("rst_in_ready", 40'(in_ready), 40'd1);
        chk("rst_out_data", 40'({out_flags, out_result}), 40'd0);

        // directed arithmetic cases
        run_one("one",      0, 127, 48'h4000_0000_0000, 2'd0, 0, 2'd0, 36'h0_3F80_0000);
        run_one("tie_rne",  0, 127, 48'h4000_0040_0000, 2'd0, 0, 2'd0, 36'h1_3F80_0000);
        run_one("tie_rup",  0, 127, 48'h4000_0040_0000, 2'd0, 0, 2'd2, 36'h1_3F80_0001);
        run_one("tie_rdn",  0, 127, 48'h4000_0040_0000, 2'd0, 0, 2'd3, 36'h1_3F80_0000);
        run_one("carry",    0, 127, 48'h7FFF_FFC0_0000, 2'd0, 0, 2'd0, 36'h1_4000_0000);
        run_one("ovf_rne",  0, 254, 48'h8000_0000_0000, 2'd0, 0, 2'd0, 36'h5_7F80_0000);
        run_one("ovf_rtz",  0, 254, 48'h8000_0000_0000, 2'd0, 0, 2'd1, 36'h5_7F7F_FFFF);
        run_one("ovf_rdn_n",1, 254, 48'h8000_0000_0000, 2'd0, 0, 2'd3, 36'h5_FF80_0000);
        run_one("ovf_rup_n",1, 254, 48'h8000_0000_0000, 2'd0, 0, 2'd2, 36'h5_FF7F_FFFF);
        run_one("unf",      0, 0,   48'h4000_0000_0001, 2'd0, 0, 2'd0, 36'h3_0000_0000);
        run_one("nan_nv",   1, 5,   48'h4000_0000_0000, 2'd3, 1, 2'd0, 36'h8_7FC0_0000);
        run_one("zero_n",   1, 5,   48'h4000_0000_0000, 2'd1, 0, 2'd0, 36'h0_8000_0000);
        run_one("inf_n",    1, 5,   48'h4000_0000_0000, 2'd2, 0, 2'd1, 36'h0_FF80_0000);

        // backpressure: three back-to-back inputs against a stalled consumer
        out_ready = 1'b0;
        apply(0, 127, 48'h4000_0000_0000, 2'd0, 0, 2'd0);
        in_valid = 1'b1;
        #1;
        exp_a = model_now();
        chk("bp_rdy_a", 40'(in_ready), 40'd1);
        @(negedge clk);
        apply(0, 127, 48'h4000_0040_0000, 2'd0, 0, 2'd2);
        #1;
        exp_b = model_now();
        chk("bp_rdy_b", 40'(in_ready), 40'd1);
        @(negedge clk);
        apply(1, 127, 48'h7FFF_FFC0_0000, 2'd0, 0, 2'd0);
        #1;
        exp_c = model_now();
        for (int i = 0; i < 4; i++) begin
            chk("bp_rdy_low", 40'(in_ready), 40'd0);
            chk("bp_valid", 40'(out_valid), 40'd1);
            chk("bp_hold_a", 40'({out_flags, out_result}), 40'(exp_a));
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", 40'(in_ready), 40'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_out_b", 40'({out_valid, out_flags, out_result}), 40'({1'b1, exp_b}));
        @(negedge clk);
        #1;
        chk("bp_out_c", 40'({out_valid, out_flags, out_result}), 40'({1'b1, exp_c}));
        @(negedge clk);
        #1;
        chk("bp_empty", 40'(out_valid), 40'd0);

        // reset with both stages occupied
        out_ready = 1'b0;
        apply(0, 127, 48'h4000_0000_0000, 2'd0, 0, 2'd0);
        in_valid = 1'b1;
        @(negedge clk);
        apply(0, 128, 48'h4000_0000_0000, 2'd0, 0, 2'd0);
        @(negedge clk);
        #1;
        chk("mid_full", 40'({out_valid, in_ready}), 40'({1'b1, 1'b0}));
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 40'(out_valid), 40'd0);
        chk("mid_rst_ready", 40'(in_ready), 40'd1);
        chk("mid_rst_data", 40'({out_flags, out_result}), 40'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("mid_rst_stale", 40'(out_valid), 40'd0);
        end

        // randomized traffic with random backpressure against the scoreboard
        hold = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #1;
            if (hold) begin
                chk("rand_hold", 40'({out_valid, out_flags, out_result}), 40'({1'b1, held}));
            end
            in_valid  = ($urandom % 4 != 0);
            out_ready = ($urandom % 3 != 0);
            rand_inputs();
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (sb.size() == 0) chk("rand_spurious", 40'd1, 40'd0);
                else chk("rand_out", 40'({out_flags, out_result}), 40'(sb.pop_front()));
            end
            hold = out_valid && !out_ready;
            held = {out_flags, out_result};
            if (fire_in) sb.push_back(model_now());
        end

        // drain what is still in flight, bounded
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard_cnt = 0;
        #1;
        while (sb.size() != 0 && guard_cnt < 20) begin
            if (out_valid) chk("drain_out", 40'({out_flags, out_result}), 40'(sb.pop_front()));
            @(negedge clk);
            #1;
            guard_cnt++;
        end
        chk("drain_empty", 40'(sb.size()), 40'd0);
        chk("drain_idle", 40'(out_valid), 40'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fmul32_round.md
# fmul32_round

Downstream rounding/packing stage for the FMUL32 multiplier datapath. Takes the unrounded sign/exponent/48-bit significand product and the operation's rounding mode, normalizes and rounds per IEEE-754 binary32, and emits the packed 32-bit result plus exception flags. It is a 2-stage valid/ready pipeline, so it can absorb downstream backpressure without losing products.

## Interface
- DATA_W, 32, packed result width
- EXP_W, 8, exponent field width
- MANT_W, 23, fraction field width; product width PW = 2*(MANT_W+1) = 48
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  product present
- in_ready  out  1  stage can accept
- in_sign  in  1  product sign
- in_exp  in  EXP_W+2  signed biased exponent, valid when significand leading 1 is at bit PW-2
- in_mant  in  PW  raw significand product
- in_class  in  2  0 normal, 1 zero, 2 inf, 3 NaN
- in_invalid  in  1  invalid-operation already detected upstream
- in_r_mode  in  2  0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (−inf)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_result  out  DATA_W  packed binary32
- out_flags  out  4  {NV, OF, UF, NX}

## Operation
- Stage 1 (normalize): if in_mant[PW-1] = 1, shift right 1 and exp+1. Keep fraction = mant[PW-3 -: MANT_W] after shift. Guard = next bit. Sticky = OR of all remaining lower bits, including the bit shifted out.
- Stage 2 (round/pack):
  - Increment decision:
    - RNE: G & (S | lsb).
    - RTZ: never.
    - RUP: ~sign & (G|S).
    - RDN: sign & (G|S).
  - NX = G|S.
  - Fraction carry-out (all ones + 1) clears the fraction and adds 1 to exp.
- Overflow, final exp ≥ 255: OF=NX=1. Result is ±inf for RNE, or when the mode rounds away from zero for that sign. Otherwise it is ±0x7F7FFFFF magnitude.
- Underflow, normalized exp ≤ 0: flush to signed zero, UF=NX=1. No subnormal outputs are produced.
- Special classes bypass rounding and set no flags except NV:
  - zero → sign<<31.
  - inf → sign, 0x7F800000.
  - NaN → 0x7FC00000.
  - NV = in_invalid for all classes.
- Exponent arithmetic is EXP_W+2-bit signed throughout. No wrap is permitted before the overflow/underflow checks.

## Timing
- Latency 2 cycles: input accepted at edge N appears with out_valid at edge N+2 when unstalled.
- Throughput 1 per cycle.
- Each stage advances when it holds data and the next stage is empty or advancing. Bubbles collapse.
- in_ready = ~s1_valid | s1_advance (combinational from out_ready).
- out_* are held stable while out_valid & ~out_ready.
- Transfer occurs only on valid & ready at the same edge. No transaction is duplicated or dropped.
- Reset values:
  - s1_valid = s2_valid = 0, so out_valid = 0 and in_ready = 1 after reset.
  - out_result = 0, out_flags = 0.
- Reset mid-operation discards all in-flight data; out_valid = 0 the cycle after rst is sampled.
- A simultaneous input accept and output drain with both stages full is legal: the pipeline shifts with no loss.

## Structure
- Shared package fp_pkg holds:
  - r_mode encodings (RM_RNE=0, RM_RTZ=1, RM_RUP=2, RM_RDN=3).
  - class encodings.
  - flag bit positions.
  - binary32 constants: QNAN 0x7FC00000, INF exp 0xFF, MAXFIN 0x7F7FFFFF.
- One sub-module: fp_round_incr, the combinational round-increment decision (mode, sign, lsb, G, S → inc, nx). It is reusable by a future FADD rounding stage.

## Test plan
- 1.0×1.0: exp=127, mant=0x4000_0000_0000, RNE, out_ready=1 → out_result 0x3F800000, flags 0, out_valid exactly 2 cycles after accept.
- Tie: exp=127, mant=0x4000_0040_0000:
  - RNE → 0x3F800000, NX.
  - RUP, sign 0 → 0x3F800001, NX.
  - RDN, sign 0 → 0x3F800000, NX.
- Carry: exp=127, mant=0x7FFF_FFC0_0000, RNE → 0x40000000, NX.
- Overflow: exp=254, mant=0x8000_0000_0000:
  - RNE → 0x7F800000, OF|NX.
  - RTZ → 0x7F7FFFFF, OF|NX.
  - exp=0, mant=0x4000_0000_0001 → 0x00000000, UF|NX.
- Backpressure: 3 back-to-back inputs with out_ready=0 for 4 cycles → in_ready low after 2 accepts, third held. Outputs then appear in order on release, values unchanged while stalled.
- Reset: assert rst 1 cycle with both stages full → out_valid=0 next cycle, in_ready=1, no stale result emitted afterward. Also class=NaN with in_invalid=1 → 0x7FC00000, NV only.
